// File: rtl/ahb_wb_pkg.sv
// ahb_wb_pkg: shared AHB/Wishbone encodings and bridge FSM states
package ahb_wb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'd0, HTRANS_BUSY = 2'd1, HTRANS_NONSEQ = 2'd2, HTRANS_SEQ = 2'd3;
  localparam logic HRESP_OKAY = 1'b0, HRESP_ERROR = 1'b1;
  typedef enum logic [2:0] {IDLE, WB_CYC, RESP, ERR1, ERR2} ahb_wb_state_e;
endpackage

// File: rtl/ahb_wb_uart_bridge.sv
// ahb_wb_uart_bridge: AHB-Lite slave to 8-bit Wishbone classic master for the UART register file
module ahb_wb_uart_bridge
  import ahb_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int AHB_WIDTH = 32
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 hsel,
  input  logic [AHB_WIDTH-1:0] haddr,
  input  logic [1:0]           htrans,
  input  logic [2:0]           hsize,
  input  logic                 hwrite,
  input  logic [AHB_WIDTH-1:0] hwdata,
  input  logic                 hready_i,
  output logic                 hready_o,
  output logic                 hresp,
  output logic [AHB_WIDTH-1:0] hrdata,
  output logic [2:0]           wb_adr_o,
  output logic [7:0]           wb_dat_o,
  input  logic [7:0]           wb_dat_i,
  output logic                 wb_we_o,
  output logic                 wb_stb_o,
  output logic                 wb_cyc_o,
  output logic [3:0]           wb_sel_o,
  input  logic                 wb_ack_i
);
  ahb_wb_state_e state, state_nxt;
  logic [2:0] adr_q;
  logic wr_q, accept, tmo, unused;
  logic [15:0] cnt;
  assign accept = hsel & htrans[1] & hready_i;
  assign tmo = cnt == 16'(TIMEOUT_CYCLES - 1);
  assign unused = ^{haddr[AHB_WIDTH-1:5], hwdata[AHB_WIDTH-1:8], hsize, htrans[0]};
  assign wb_adr_o = adr_q;
  assign wb_dat_o = hwdata[7:0];
  assign wb_sel_o = 4'b0001;
  always_ff @(posedge wb_clk_i)
    state <= wb_rst_i ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == WB_CYC) state_nxt = wb_ack_i ? RESP : tmo ? ERR1 : WB_CYC;
    else if (state == ERR1) state_nxt = ERR2;
    else state_nxt = !accept ? IDLE : (haddr[1:0] != 2'b00) ? ERR1 : WB_CYC;
  end
  always_comb begin
    wb_cyc_o = state == WB_CYC;
    wb_stb_o = wb_cyc_o;
    wb_we_o  = wb_cyc_o & wr_q;
    hready_o = !(state == WB_CYC || state == ERR1);
    hresp    = (state == ERR1 || state == ERR2) ? HRESP_ERROR : HRESP_OKAY;
  end
  // counter idles at zero outside WB_CYC so every Wishbone cycle starts from a fresh count
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt    <= '0;
      adr_q  <= '0;
      wr_q   <= 1'b0;
      hrdata <= '0;
    end else begin
      cnt <= (state != WB_CYC) ? '0 : cnt + {15'd0, cnt != 16'hFFFF};
      if (accept) begin
        adr_q <= haddr[4:2];
        wr_q  <= hwrite;
      end
      if (state == WB_CYC && wb_ack_i && !wr_q) hrdata <= {{(AHB_WIDTH-8){1'b0}}, wb_dat_i};
    end
  end
endmodule
